// File: rtl/control_sequencer_pkg.sv
// control_pkg: shared definitions for the microcode sequencer.
//   - state_t      : sequencer FSM states
//   - B_*          : bit positions of every field in the 32-bit microcode word
//   - CTRL_IDLE    : control word with every memory-stage action deasserted
//   - CTRL_FETCH   : CTRL_IDLE plus instruction-register write and PC increment
//   - STEP_W       : microstep counter width
package control_pkg;

  localparam int STEP_W  = 3;
  localparam int OPC_W   = 8;
  localparam int FLAG_W  = 4;
  localparam int ADDR_W  = OPC_W + FLAG_W + STEP_W;  // 15
  localparam int UWORD_W = 32;
  localparam int CTRL_W  = 30;                       // bits 29:0 drive outputs
  localparam int OTHER_W = 17;

  localparam logic [STEP_W-1:0] STEP_MAX = '1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Microcode word bit positions.
  localparam int B_PC_LOAD_N      = 0;
  localparam int B_PC_NEN         = 1;
  localparam int B_PC0_FROM_BUS_N = 2;
  localparam int B_PC1_FROM_BUS_N = 3;
  localparam int B_SP_UP          = 4;
  localparam int B_SP_NEN         = 5;
  localparam int B_INSTR_NWE      = 6;
  localparam int B_INSTR_NOE      = 7;
  localparam int B_RAM_NOE        = 8;
  localparam int B_RAM_NWE        = 9;
  localparam int B_MAR0_NWE       = 10;
  localparam int B_MAR1_NWE       = 11;
  localparam int B_IMM_TO_RAM     = 12;
  localparam int B_OTHER_LO       = 13;
  localparam int B_OTHER_HI       = 29;
  localparam int B_HALT           = 30;
  localparam int B_LAST           = 31;

  // Active-low controls high, SpUp/ImmToRam low, pass-through bundle zero.
  localparam logic [CTRL_W-1:0] CTRL_IDLE  = 30'h0000_0FEF;
  // Idle with InstrNWE (bit 6) and PCNEn (bit 1) asserted low.
  localparam logic [CTRL_W-1:0] CTRL_FETCH = 30'h0000_0FAD;

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: microcode ROM bus plus memory-stage control bundle.
//   master (sequencer): drives o_microAddress and all o_ctrl* lines,
//                       receives i_microData.
//   slave  (ROM / memory stage): the reverse.
// There is no valid/ready handshake on this bus: the ROM is an asynchronous
// read, so i_microData is valid in the same cycle as o_microAddress, and the
// control lines are sampled by the memory stage on every rising clock edge.
interface control_sequencer_if;
  import control_pkg::*;

  logic [ADDR_W-1:0]  o_microAddress;
  logic [UWORD_W-1:0] i_microData;

  logic o_ctrlPCLoadN;
  logic o_ctrlPCNEn;
  logic o_ctrlPC0FromBusN;
  logic o_ctrlPC1FromBusN;
  logic o_ctrlSpUp;
  logic o_ctrlSpNEn;
  logic o_ctrlInstrNWE;
  logic o_ctrlInstrNOE;
  logic o_ctrlRamNOE;
  logic o_ctrlRamNWE;
  logic o_ctrlMemMar0NWE;
  logic o_ctrlMemMar1NWE;
  logic o_ctrlMemInstrImmToRam;
  logic [OTHER_W-1:0] o_ctrlOther;

  modport master (
    output o_microAddress,
    input  i_microData,
    output o_ctrlPCLoadN, o_ctrlPCNEn, o_ctrlPC0FromBusN, o_ctrlPC1FromBusN,
    output o_ctrlSpUp, o_ctrlSpNEn, o_ctrlInstrNWE, o_ctrlInstrNOE,
    output o_ctrlRamNOE, o_ctrlRamNWE, o_ctrlMemMar0NWE, o_ctrlMemMar1NWE,
    output o_ctrlMemInstrImmToRam, o_ctrlOther
  );

  modport slave (
    input  o_microAddress,
    output i_microData,
    input  o_ctrlPCLoadN, o_ctrlPCNEn, o_ctrlPC0FromBusN, o_ctrlPC1FromBusN,
    input  o_ctrlSpUp, o_ctrlSpNEn, o_ctrlInstrNWE, o_ctrlInstrNOE,
    input  o_ctrlRamNOE, o_ctrlRamNWE, o_ctrlMemMar0NWE, o_ctrlMemMar1NWE,
    input  o_ctrlMemInstrImmToRam, o_ctrlOther
  );

endinterface

// File: rtl/control_sequencer_edge_detect.sv
// edge_detect: one-register rising-edge detector.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_sig          : synchronous level input
//   o_rise         : high for the cycle where i_sig is 1 and was 0 last cycle
module edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  // Updated every cycle regardless of consumer state, so a held level
  // produces exactly one pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_prev <= 1'b0;
    else         r_prev <= i_sig;
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: microcode sequencer for the 8-bit CPU.
//   i_clk, i_reset   : clock, asynchronous active-high reset
//   i_instrCode      : opcode latched by the memory stage
//   i_flags          : ALU flags {N,V,Z,C}, captured at fetch
//   i_breakpointHit  : PC matches enabled breakpoint
//   i_haltReq        : halt at next instruction boundary
//   i_runMode        : 0 free run, 1 single step
//   i_stepPulse      : resume/step request (rising edge used)
//   o_halted         : high in HALT
//   o_microFault     : sticky, EXEC ran past step 7 without LAST
//   o_step           : current microstep
//   o_state          : current FSM state (debug)
//   bus              : ROM address/data and memory-stage controls
module control_sequencer
  import control_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [OPC_W-1:0]    i_instrCode,
  input  logic [FLAG_W-1:0]   i_flags,
  input  logic                i_breakpointHit,
  input  logic                i_haltReq,
  input  logic                i_runMode,
  input  logic                i_stepPulse,
  output logic                o_halted,
  output logic                o_microFault,
  output logic [STEP_W-1:0]   o_step,
  output state_t              o_state,
  control_sequencer_if.master bus
);

  state_t              r_state, w_next_state;
  logic [STEP_W-1:0]   r_step, w_next_step;
  logic [FLAG_W-1:0]   r_flags, w_next_flags;
  logic                r_bpSkip, w_next_bpSkip;
  logic                r_fault, w_next_fault;
  logic                w_step_rise;
  logic                w_stop;
  logic [CTRL_W-1:0]   w_ctrl;

  edge_detect u_step_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_stepPulse),
    .o_rise  (w_step_rise)
  );

  // The breakpoint is ignored for the one fetch right after a resume so
  // execution can leave the breakpoint address.
  assign w_stop = i_haltReq | (i_breakpointHit & ~r_bpSkip);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_FETCH;
      r_step   <= '0;
      r_flags  <= '0;
      r_bpSkip <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_step   <= w_next_step;
      r_flags  <= w_next_flags;
      r_bpSkip <= w_next_bpSkip;
      r_fault  <= w_next_fault;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_step   = r_step;
    w_next_flags  = r_flags;
    w_next_bpSkip = r_bpSkip;
    w_next_fault  = r_fault;
    w_ctrl        = CTRL_IDLE;

    unique case (r_state)
      ST_FETCH: begin
        if (w_stop) begin
          w_next_state = ST_HALT;
        end else begin
          w_ctrl        = CTRL_FETCH;
          w_next_state  = ST_EXEC;
          w_next_step   = 3'd1;
          w_next_flags  = i_flags;
          w_next_bpSkip = 1'b0;
        end
      end

      ST_EXEC: begin
        w_ctrl = bus.i_microData[CTRL_W-1:0];
        if (bus.i_microData[B_HALT]) begin
          w_next_state = ST_HALT;
          w_next_step  = '0;
        end else if (bus.i_microData[B_LAST] || (r_step == STEP_MAX)) begin
          // A sequence that runs off the end of the step counter is
          // terminated as if LAST were set, and flagged.
          if (!bus.i_microData[B_LAST]) w_next_fault = 1'b1;
          w_next_step  = '0;
          w_next_state = i_runMode ? ST_HALT : ST_FETCH;
        end else begin
          w_next_step = r_step + 3'd1;
        end
      end

      ST_HALT: begin
        if (w_step_rise) begin
          w_next_state  = ST_FETCH;
          w_next_bpSkip = 1'b1;
        end
      end

      default: begin
        w_next_state = ST_FETCH;
        w_next_step  = '0;
      end
    endcase

    // No partial controls may reach the memory stage while reset is held.
    if (i_reset) w_ctrl = CTRL_IDLE;
  end

  assign bus.o_microAddress         = {i_instrCode, r_flags, r_step};
  assign bus.o_ctrlPCLoadN          = w_ctrl[B_PC_LOAD_N];
  assign bus.o_ctrlPCNEn            = w_ctrl[B_PC_NEN];
  assign bus.o_ctrlPC0FromBusN      = w_ctrl[B_PC0_FROM_BUS_N];
  assign bus.o_ctrlPC1FromBusN      = w_ctrl[B_PC1_FROM_BUS_N];
  assign bus.o_ctrlSpUp             = w_ctrl[B_SP_UP];
  assign bus.o_ctrlSpNEn            = w_ctrl[B_SP_NEN];
  assign bus.o_ctrlInstrNWE         = w_ctrl[B_INSTR_NWE];
  assign bus.o_ctrlInstrNOE         = w_ctrl[B_INSTR_NOE];
  assign bus.o_ctrlRamNOE           = w_ctrl[B_RAM_NOE];
  assign bus.o_ctrlRamNWE           = w_ctrl[B_RAM_NWE];
  assign bus.o_ctrlMemMar0NWE       = w_ctrl[B_MAR0_NWE];
  assign bus.o_ctrlMemMar1NWE       = w_ctrl[B_MAR1_NWE];
  assign bus.o_ctrlMemInstrImmToRam = w_ctrl[B_IMM_TO_RAM];
  assign bus.o_ctrlOther            = w_ctrl[B_OTHER_HI:B_OTHER_LO];

  assign o_halted     = (r_state == ST_HALT);
  assign o_microFault = r_fault;
  assign o_step       = r_step;
  assign o_state      = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  import control_pkg::*;

  localparam logic [29:0] EXP_IDLE  = 30'h0000_0FEF;
  localparam logic [29:0] EXP_FETCH = 30'h0000_0FAD;
  localparam logic [7:0]  OP_HALT   = 8'hE0;
  localparam logic [7:0]  OP_FAULT  = 8'hF0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] instr;
  logic [3:0] flags;
  logic       bp, haltreq, runmode, steppulse;
  logic       halted, fault;
  logic [2:0] step;
  state_t     st;

  control_sequencer_if bus ();

  control_sequencer dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_instrCode     (instr),
    .i_flags         (flags),
    .i_breakpointHit (bp),
    .i_haltReq       (haltreq),
    .i_runMode       (runmode),
    .i_stepPulse     (steppulse),
    .o_halted        (halted),
    .o_microFault    (fault),
    .o_step          (step),
    .o_state         (st),
    .bus             (bus)
  );

  // ---------------- microcode ROM model ----------------
  logic [31:0] rom_mem [0:32767];
  int          op_len  [0:255];
  assign bus.i_microData = rom_mem[bus.o_microAddress];

  logic [29:0] obs_ctrl;
  assign obs_ctrl = {bus.o_ctrlOther, bus.o_ctrlMemInstrImmToRam,
                     bus.o_ctrlMemMar1NWE, bus.o_ctrlMemMar0NWE,
                     bus.o_ctrlRamNWE, bus.o_ctrlRamNOE, bus.o_ctrlInstrNOE,
                     bus.o_ctrlInstrNWE, bus.o_ctrlSpNEn, bus.o_ctrlSpUp,
                     bus.o_ctrlPC1FromBusN, bus.o_ctrlPC0FromBusN,
                     bus.o_ctrlPCNEn, bus.o_ctrlPCLoadN};

  int checks = 0;
  int errors = 0;

  // Program: each opcode has a length in microsteps; LAST is on that step.
  // OP_HALT carries HALT at step 2, OP_FAULT never sets LAST.
  task automatic build_rom();
    logic [7:0] op;
    logic [2:0] s;
    for (int o = 0; o < 256; o++) op_len[o] = $urandom_range(1, 7);
    op_len[8'h10] = 1;
    op_len[8'h21] = 2; op_len[8'h22] = 2; op_len[8'h23] = 2;
    op_len[8'h30] = 6;
    op_len[OP_HALT]  = 5;
    op_len[OP_FAULT] = 99;
    for (int a = 0; a < 32768; a++) begin
      op = 8'(a >> 7);
      s  = 3'(a);
      rom_mem[a][29:0] = 30'($urandom);
      rom_mem[a][31]   = (int'(s) == op_len[op]);
      rom_mem[a][30]   = (op == OP_HALT) && (s == 3'd2);
      if (op == 8'h10 && s == 3'd1) rom_mem[a][29:0] = {17'h00001, 13'h0FEF};
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; instr = 8'h10; flags = 4'hA; bp = 0; haltreq = 0;
    runmode = 0; steppulse = 0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs_ctrl !== EXP_IDLE || step !== 3'd0 || halted !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ctrl=%h step=%0d halted=%b fault=%b, expected ctrl=%h step=0 halted=0 fault=0",
               obs_ctrl, step, halted, fault, EXP_IDLE);
    end
    checks++;
    if (bus.o_microAddress !== {8'h10, 4'h0, 3'd0}) begin
      errors++;
      $display("FAIL reset_addr: got %h expected %h", bus.o_microAddress, {8'h10, 4'h0, 3'd0});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0]  f;
    logic [14:0] a;
    for (int rep = 0; rep < 2; rep++) begin
      f = 4'($urandom_range(0, 15));
      @(negedge clk); instr = 8'h10; flags = f; #1;
      checks++;
      if (obs_ctrl !== EXP_FETCH || step !== 3'd0) begin
        errors++;
        $display("FAIL basic_fetch%0d: ctrl=%h step=%0d expected ctrl=%h step=0", rep, obs_ctrl, step, EXP_FETCH);
      end
      @(negedge clk); #1;
      a = {8'h10, f, 3'd1};
      checks++;
      if (bus.o_microAddress !== a || bus.o_ctrlOther !== 17'h00001) begin
        errors++;
        $display("FAIL basic_step1_%0d: addr=%h other=%h expected addr=%h other=00001",
                 rep, bus.o_microAddress, bus.o_ctrlOther, a);
      end
    end
  endtask

  task automatic test_flags();
    logic [14:0] a;
    @(negedge clk); instr = 8'h30; flags = 4'h1; #1;
    for (int s = 1; s <= 6; s++) begin
      @(negedge clk); flags = (s == 1) ? 4'h0 : 4'($urandom_range(0, 15)); #1;
      a = {8'h30, 4'h1, 3'(s)};
      checks++;
      if (bus.o_microAddress !== a || obs_ctrl !== rom_mem[a][29:0]) begin
        errors++;
        $display("FAIL flags_step%0d: addr=%h ctrl=%h expected addr=%h ctrl=%h",
                 s, bus.o_microAddress, obs_ctrl, a, rom_mem[a][29:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  op;
    logic [3:0]  f;
    logic [14:0] a;
    for (int n = 0; n < 25; n++) begin
      do op = 8'($urandom_range(0, 255)); while (op == OP_HALT || op == OP_FAULT);
      f = 4'($urandom_range(0, 15));
      @(negedge clk); instr = op; flags = f; #1;
      checks++;
      if (obs_ctrl !== EXP_FETCH || step !== 3'd0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL b2b_fetch op=%h: ctrl=%h step=%0d halted=%b expected ctrl=%h step=0 halted=0",
                 op, obs_ctrl, step, halted, EXP_FETCH);
      end
      for (int s = 1; s <= op_len[op]; s++) begin
        @(negedge clk); flags = 4'($urandom_range(0, 15)); #1;
        a = {op, f, 3'(s)};
        checks++;
        if (bus.o_microAddress !== a || obs_ctrl !== rom_mem[a][29:0]) begin
          errors++;
          $display("FAIL b2b_exec op=%h step=%0d: addr=%h ctrl=%h expected addr=%h ctrl=%h",
                   op, s, bus.o_microAddress, obs_ctrl, a, rom_mem[a][29:0]);
        end
      end
    end
  endtask

  task automatic test_breakpoint();
    // Fetch with breakpoint: stop, PC idle.
    @(negedge clk); instr = 8'h10; flags = 4'h3; bp = 1; #1;
    checks++;
    if (obs_ctrl !== EXP_IDLE || halted !== 1'b0) begin
      errors++;
      $display("FAIL bp_stop: ctrl=%h halted=%b expected ctrl=%h halted=0", obs_ctrl, halted, EXP_IDLE);
    end
    @(negedge clk); #1;
    checks++;
    if (halted !== 1'b1 || obs_ctrl !== EXP_IDLE) begin
      errors++;
      $display("FAIL bp_halted: halted=%b ctrl=%h expected halted=1 ctrl=%h", halted, obs_ctrl, EXP_IDLE);
    end
    @(negedge clk); steppulse = 1; #1;
    // Resume: fetch proceeds even though the breakpoint is still hit.
    @(negedge clk); steppulse = 0; #1;
    checks++;
    if (halted !== 1'b0 || obs_ctrl !== EXP_FETCH) begin
      errors++;
      $display("FAIL bp_resume_fetch: halted=%b ctrl=%h expected halted=0 ctrl=%h", halted, obs_ctrl, EXP_FETCH);
    end
    @(negedge clk); bp = 0; #1;
    checks++;
    if (bus.o_microAddress !== {8'h10, 4'h3, 3'd1}) begin
      errors++;
      $display("FAIL bp_resume_exec: addr=%h expected %h", bus.o_microAddress, {8'h10, 4'h3, 3'd1});
    end
    @(negedge clk); #1;
    checks++;
    if (obs_ctrl !== EXP_FETCH) begin
      errors++;
      $display("FAIL bp_next_fetch: ctrl=%h expected %h", obs_ctrl, EXP_FETCH);
    end
    @(negedge clk); #1;
    // The skip covers one fetch only: a hit at the following fetch stops again.
    @(negedge clk); bp = 1; #1;
    checks++;
    if (obs_ctrl !== EXP_IDLE) begin
      errors++;
      $display("FAIL bp_rearm: ctrl=%h expected %h", obs_ctrl, EXP_IDLE);
    end
    @(negedge clk); bp = 0; steppulse = 1; #1;
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL bp_rearm_halt: halted=%b expected 1", halted);
    end
    @(negedge clk); steppulse = 0; #1;
    @(negedge clk); #1;
  endtask

  task automatic test_step_mode();
    logic [7:0]  op;
    logic [3:0]  f;
    logic        exp_h;
    @(negedge clk); haltreq = 1; #1;
    @(negedge clk); haltreq = 0; runmode = 1; #1;
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL step_enter_halt: halted=%b expected 1", halted);
    end
    for (int i = 0; i < 3; i++) begin
      op = 8'(8'h21 + i);
      f  = 4'($urandom_range(0, 15));
      @(negedge clk); steppulse = 1; instr = op; #1;
      for (int c = 1; c <= 7; c++) begin
        @(negedge clk);
        if (c == 5) steppulse = 0;
        if (c == 1) flags = f;
        #1;
        exp_h = (c > 3);
        checks++;
        if (halted !== exp_h) begin
          errors++;
          $display("FAIL step_halted i=%0d c=%0d: halted=%b expected %b", i, c, halted, exp_h);
        end
        if (c == 2 || c == 3) begin
          checks++;
          if (bus.o_microAddress !== {op, f, 3'(c - 1)}) begin
            errors++;
            $display("FAIL step_addr i=%0d c=%0d: addr=%h expected %h", i, c, bus.o_microAddress, {op, f, 3'(c - 1)});
          end
        end
      end
    end
    runmode = 0;
    @(negedge clk); steppulse = 1;
    @(posedge clk); #1 steppulse = 0;
  endtask

  task automatic test_halt_bit();
    @(negedge clk); instr = OP_HALT; flags = 4'h5; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (obs_ctrl !== rom_mem[{OP_HALT, 4'h5, 3'd2}][29:0]) begin
      errors++;
      $display("FAIL haltbit_ctrl: ctrl=%h expected %h", obs_ctrl, rom_mem[{OP_HALT, 4'h5, 3'd2}][29:0]);
    end
    @(negedge clk); #1;
    checks++;
    if (halted !== 1'b1 || step !== 3'd0 || obs_ctrl !== EXP_IDLE) begin
      errors++;
      $display("FAIL haltbit_halted: halted=%b step=%0d ctrl=%h expected halted=1 step=0 ctrl=%h",
               halted, step, obs_ctrl, EXP_IDLE);
    end
    steppulse = 1;
    @(posedge clk); #1 steppulse = 0;
  endtask

  task automatic test_fault();
    logic [14:0] a;
    @(negedge clk); instr = OP_FAULT; flags = 4'h9; #1;
    for (int s = 1; s <= 7; s++) begin
      @(negedge clk); #1;
      a = {OP_FAULT, 4'h9, 3'(s)};
      checks++;
      if (bus.o_microAddress !== a || fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_step%0d: addr=%h fault=%b expected addr=%h fault=0", s, bus.o_microAddress, fault, a);
      end
    end
    @(negedge clk); instr = 8'h10; flags = 4'h2; #1;
    checks++;
    if (fault !== 1'b1 || obs_ctrl !== EXP_FETCH || step !== 3'd0) begin
      errors++;
      $display("FAIL fault_set: fault=%b ctrl=%h step=%0d expected fault=1 ctrl=%h step=0",
               fault, obs_ctrl, step, EXP_FETCH);
    end
    @(negedge clk); #1;
    checks++;
    if (fault !== 1'b1 || bus.o_microAddress !== {8'h10, 4'h2, 3'd1}) begin
      errors++;
      $display("FAIL fault_sticky: fault=%b addr=%h expected fault=1 addr=%h", fault, bus.o_microAddress, {8'h10, 4'h2, 3'd1});
    end
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk); instr = 8'h30; flags = 4'h7; #1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (step !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_pre: step=%0d expected 3", step);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (step !== 3'd0 || obs_ctrl !== EXP_IDLE || halted !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: step=%0d ctrl=%h halted=%b fault=%b expected step=0 ctrl=%h halted=0 fault=0",
               step, obs_ctrl, halted, fault, EXP_IDLE);
    end
    @(negedge clk); #1;
    checks++;
    if (obs_ctrl !== EXP_IDLE || bus.o_microAddress !== {8'h30, 4'h0, 3'd0}) begin
      errors++;
      $display("FAIL rstmid_held: ctrl=%h addr=%h expected ctrl=%h addr=%h",
               obs_ctrl, bus.o_microAddress, EXP_IDLE, {8'h30, 4'h0, 3'd0});
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (obs_ctrl !== EXP_FETCH) begin
      errors++;
      $display("FAIL rstmid_refetch: ctrl=%h expected %h", obs_ctrl, EXP_FETCH);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    build_rom();
    test_reset();
    test_basic();
    test_flags();
    test_back_to_back();
    test_breakpoint();
    test_step_mode();
    test_halt_bit();
    test_fault();
    test_reset_mid_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
